// File: rtl/fp_adder_arbiter.sv
// fp_adder_arbiter: shares one fixed-latency FP adder between NUM_REQ
// requesters. Issue slots are granted round-robin (fixed priority when
// FP_ADDER_ARB_FIXED_PRIO_EN is defined). A valid/tag delay line matched to
// ADD_LATENCY follows each operation. Results are queued in a credit-protected
// FIFO and returned in issue order with the requester tag.
// Optional build macro: FP_ADDER_ARB_FIXED_PRIO_EN (lowest index wins, no rr_ptr).

`ifndef FP16
`define FP16 0
`endif
`ifndef FP32
`define FP32 1
`endif
`ifndef FP64
`define FP64 2
`endif
`ifndef BF16
`define BF16 3
`endif

module fp_adder_arbiter #(
   parameter int data_format = `FP32,
   parameter int DATA_W      = 32,
   parameter int NUM_REQ     = 4,
   parameter int ADD_LATENCY = 3,
   parameter int FIFO_DEPTH  = 4,
   parameter int TAG_W       = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
   output logic                      add_in_valid,
   output logic [DATA_W-1:0]         add_a,
   output logic [DATA_W-1:0]         add_b,
   input  logic                      add_out_valid,
   input  logic [DATA_W-1:0]         add_result,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         out_result,
   output logic [TAG_W-1:0]          out_tag,
   output logic                      err
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int IGN_W = $clog2(ADD_LATENCY + 1);
   localparam int FMT_W = (data_format == `FP16) ? 16 :
                          (data_format == `BF16) ? 16 :
                          (data_format == `FP64) ? 64 : 32;

   // Reject configurations whose operand width disagrees with the format
   // or whose sizes fall outside the supported range.
   generate
      if (FMT_W != DATA_W || NUM_REQ < 2 || NUM_REQ > 8 || ADD_LATENCY < 1 ||
          FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
         $error("fp_adder_arbiter: unsupported parameter combination");
      end
   endgenerate

   // Per-requester operand views of the packed buses
   logic [DATA_W-1:0] req_a_arr [NUM_REQ];
   logic [DATA_W-1:0] req_b_arr [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign req_a_arr[gi] = req_a[gi*DATA_W +: DATA_W];
         assign req_b_arr[gi] = req_b[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // State
   logic [ADD_LATENCY-1:0] dl_valid_q;
   logic [TAG_W-1:0]       dl_tag_q [ADD_LATENCY];
   logic [IGN_W-1:0]       ign_q;
   logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   err_q, err_d;
   logic [DATA_W-1:0]      mem_q [FIFO_DEPTH];
   logic [TAG_W-1:0]       tag_mem_q [FIFO_DEPTH];

   logic [31:0]      credits_used;
   logic             credit_ok;
   logic             grant_found;
   logic [TAG_W-1:0] grant_idx;
   logic             issue;

   // Credits: every in-flight op plus every buffered result holds one slot
   always_comb begin
      credits_used = 32'($countones(dl_valid_q)) + 32'(cnt_q);
      credit_ok    = credits_used < 32'(FIFO_DEPTH);
   end

`ifdef FP_ADDER_ARB_FIXED_PRIO_EN
   // Fixed priority: lowest-index valid requester wins
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            grant_found = 1'b1;
            grant_idx   = TAG_W'(i);
         end
      end
   end
`else
   logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [TAG_W-1:0] rr_idx;

   // Round-robin: first valid requester at or after rr_ptr, wrapping
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      rr_idx      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rr_idx = TAG_W'((int'(rr_ptr_q) + i) % NUM_REQ);
         if (!grant_found && req_valid[rr_idx]) begin
            grant_found = 1'b1;
            grant_idx   = rr_idx;
         end
      end
   end

   // Pointer moves past the granted requester only when an op is issued
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (issue) begin
         rr_ptr_d = (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);
      end
   end

   // Round-robin pointer register
   always_ff @(posedge clk) begin
      if (rst) rr_ptr_q <= '0;
      else     rr_ptr_q <= rr_ptr_d;
   end
`endif

   // Nothing is granted while reset is held
   assign issue = grant_found & credit_ok & ~rst;

   // One-hot grant and issue datapath (operands forced to 0 when idle)
   always_comb begin
      req_ready = '0;
      if (issue) req_ready[grant_idx] = 1'b1;
   end

   assign add_in_valid = |(req_valid & req_ready);
   assign add_a        = add_in_valid ? req_a_arr[grant_idx] : '0;
   assign add_b        = add_in_valid ? req_b_arr[grant_idx] : '0;

   // Retire side: adder strobes are ignored for ADD_LATENCY cycles after reset
   // so results of operations issued before reset are dropped.
   logic             ret_valid;
   logic             fifo_full;
   logic             push, pop;
   logic [TAG_W-1:0] ret_tag;

   assign ret_valid = add_out_valid & (ign_q == '0) & ~rst;
   assign ret_tag   = dl_tag_q[ADD_LATENCY-1];
   assign fifo_full = (cnt_q == CNT_W'(FIFO_DEPTH));
   assign push      = ret_valid & ~fifo_full;
   assign pop       = out_valid & out_ready;

   // FIFO occupancy and sticky error next-state
   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
      err_d = err_q | (ret_valid != dl_valid_q[ADD_LATENCY-1]) | (ret_valid & fifo_full);
   end

   // Tag delay line, reset guard counter, FIFO pointers and error flag
   always_ff @(posedge clk) begin
      if (rst) begin
         dl_valid_q <= '0;
         for (int i = 0; i < ADD_LATENCY; i++) dl_tag_q[i] <= '0;
         ign_q    <= IGN_W'(ADD_LATENCY);
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         dl_valid_q[0] <= add_in_valid;
         dl_tag_q[0]   <= grant_idx;
         for (int i = 1; i < ADD_LATENCY; i++) begin
            dl_valid_q[i] <= dl_valid_q[i-1];
            dl_tag_q[i]   <= dl_tag_q[i-1];
         end
         if (ign_q != '0) ign_q <= ign_q - IGN_W'(1);
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   // Result storage; contents are only meaningful below the count
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q]     <= add_result;
         tag_mem_q[wr_ptr_q] <= ret_tag;
      end
   end

   assign out_valid  = (cnt_q != '0);
   assign out_result = out_valid ? mem_q[rd_ptr_q] : '0;
   assign out_tag    = out_valid ? tag_mem_q[rd_ptr_q] : '0;
   assign err        = err_q;

endmodule

// File: doc/fp_adder_arbiter.md
# fp_adder_arbiter

Shares one fixed-latency floating-point adder pipeline between `NUM_REQ` requesters. It grants issue slots round-robin and tracks each in-flight operation's requester tag in a delay line matched to the adder latency. Completed results land in a credit-protected output FIFO, which returns them with their tag. It sits between the requesting engines and the adder pipeline (alignment, mantissa calculation, normalisation stages).

## Interface
- `data_format`, default `` `FP32 ``: format passed through to the adder; selects operand width.
- `DATA_W`, default 32: operand/result width; must equal the total width of `data_format`.
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ADD_LATENCY`, default 3: cycles from `add_in_valid` to `add_out_valid`, ≥1.
- `FIFO_DEPTH`, default 4: result FIFO entries, a power of 2, ≥2.
- `TAG_W`, default `$clog2(NUM_REQ)`: tag width.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: request per requester.
- `req_ready` out NUM_REQ: one-hot grant, at most one bit set.
- `req_a` in NUM_REQ*DATA_W: operand A per requester, packed, requester 0 in LSBs.
- `req_b` in NUM_REQ*DATA_W: operand B per requester, packed.
- `add_in_valid` out 1: issue strobe to the adder.
- `add_a` out DATA_W: operand A to the adder.
- `add_b` out DATA_W: operand B to the adder.
- `add_out_valid` in 1: adder result strobe.
- `add_result` in DATA_W: adder result.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: consumer accept.
- `out_result` out DATA_W: FIFO head result.
- `out_tag` out TAG_W: requester index of the FIFO head.
- `err` out 1: sticky protocol error.

## Operation
- Credit count: `credits_used = inflight + fifo_count`. `inflight` is the number of set bits in the valid delay line, range 0..ADD_LATENCY.
- Issue condition: `credits_used < FIFO_DEPTH` and at least one `req_valid` bit set.
  - A same-cycle FIFO pop does not free a credit until the next cycle.
- Arbitration: round-robin.
  - Pointer `rr_ptr` resets to 0.
  - The grant goes to the first valid requester at or after `rr_ptr`, wrapping modulo NUM_REQ.
  - After a grant to requester g, `rr_ptr` becomes (g+1) mod NUM_REQ.
  - The pointer does not move when nothing is issued.
- Handshake: `req_ready[g]` is asserted only for the granted requester. A transfer occurs when `req_valid[g] && req_ready[g]`.
- Issue datapath:
  - `add_in_valid = |(req_valid & req_ready)`; purely combinational.
  - `add_a`/`add_b` take the granted requester's operands.
  - `add_a`/`add_b` are 0 when nothing is issued.
- Tag delay line: ADD_LATENCY stages of {valid, tag}. The issue cycle loads stage 0; stage ADD_LATENCY-1 is the retire stage.
- Retire: when `add_out_valid`, push {`add_result`, retire tag} into the FIFO.
- FIFO: circular buffer with read/write pointers and count. Pointers wrap at FIFO_DEPTH.
- FIFO boundaries:
  - Push and pop in the same cycle leave the count unchanged.
  - A push into a full FIFO is impossible by credit construction. If it occurs, set `err` and drop the push.
- Sticky error: `err` is set when `add_out_valid` differs from the retire-stage valid bit. It clears only on `rst`.
- Results return in issue order. `out_tag` identifies the requester.

## Timing
- Reset values: `req_ready`=0, `add_in_valid`=0, `add_a`=`add_b`=0, `out_valid`=0, `out_result`=0, `out_tag`=0, `err`=0.
  - `rr_ptr`, the delay line and the FIFO pointers/count all clear to 0.
- Reset mid-operation: in-flight tags are discarded, and `add_out_valid` is ignored for ADD_LATENCY cycles after reset. Buffered results are discarded.
- Latency:
  - Issue at cycle t; adder result at t+ADD_LATENCY.
  - The FIFO write happens at that edge, so `out_valid` is earliest at t+ADD_LATENCY+1.
- Throughput: one issue per cycle while credits remain.
  - The credit limit caps sustained throughput at FIFO_DEPTH/(ADD_LATENCY+1) when the output is drained each cycle.
- Outputs `out_valid`/`out_result`/`out_tag` are registered FIFO head state; no combinational path from `out_ready`.
- `req_ready` depends combinationally on `req_valid`, `rr_ptr` and the credit state.

## Configuration
- `FP_ADDER_ARB_FIXED_PRIO_EN`
  - Defined: fixed-priority arbitration; the lowest requester index wins and `rr_ptr` is removed.
  - Undefined (default): round-robin as above.
- All other behaviour is identical either way.

## Test plan
- Reset then idle: assert `rst` for 2 cycles, no requests → all outputs 0 and `err`=0 for 20 cycles.
- Single op: requester 2 issues a=0x3F800000, b=0x40000000 at t; adder model returns 0x40400000 at t+3 → `out_valid` at t+4 with `out_result`=0x40400000, `out_tag`=2; `err`=0.
- Round-robin fairness: all 4 requesters hold `req_valid`, `out_ready`=1 → grant sequence 0,1,2,3,0 over the issue cycles; no requester is starved.
  - With `FP_ADDER_ARB_FIXED_PRIO_EN` defined → requester 0 wins every issue cycle.
- Credit backpressure: `out_ready`=0, continuous requests → exactly 4 issues, then `req_ready`=0.
  - FIFO reaches full with `out_valid`=1.
  - Raising `out_ready` for 1 cycle → exactly 1 new issue on the following cycle.
- Protocol error: adder model asserts a spurious `add_out_valid` with nothing in flight → `err`=1 on the next cycle and it stays set until `rst`.
- Reset mid-flight: 2 ops in flight, `rst` for 1 cycle → the late `add_out_valid` pulses are ignored, `out_valid` stays 0 and `err` stays 0.
